// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: captures decoded fields and register file operands, bypasses
// same-edge writeback data, and bubbles EX on load-use hazards with a saturating bubble counter.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] id_wn,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_wn,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_wn,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              r_ex_valid;
  logic [ADDR_W-1:0] r_ex_rs;
  logic [ADDR_W-1:0] r_ex_rt;
  logic [ADDR_W-1:0] r_ex_wn;
  logic              r_ex_reg_write;
  logic              r_ex_mem_read;
  logic [DATA_W-1:0] r_ex_op_a;
  logic [DATA_W-1:0] r_ex_op_b;
  logic [CNT_W-1:0]  r_bubble_count;

  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic              w_hazard;
  logic              w_rs_dep;
  logic              w_rt_dep;

  // Register 0 reads as zero; a write landing on this edge overrides the stale read.
  function automatic logic [DATA_W-1:0] sel_operand(
    input logic [ADDR_W-1:0] rn,
    input logic [DATA_W-1:0] rd,
    input logic              we,
    input logic [ADDR_W-1:0] wn,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] v;
    if (rn == {ADDR_W{1'b0}}) begin
      v = {DATA_W{1'b0}};
    end else if (we && (wn != {ADDR_W{1'b0}}) && (wn == rn)) begin
      v = wd;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Operand selection and load-use hazard detection.
  always_comb begin
    w_op_a   = sel_operand(id_rs, rd1, wb_we, wb_wn, wb_wd);
    w_op_b   = sel_operand(id_rt, rd2, wb_we, wb_wn, wb_wd);
    w_rs_dep = (r_ex_wn == id_rs);
    w_rt_dep = id_uses_rt && (r_ex_wn == id_rt);
    w_hazard = 1'b0;
    if (!reset && !flush && id_valid && r_ex_valid && r_ex_mem_read &&
        (r_ex_wn != {ADDR_W{1'b0}}) && (w_rs_dep || w_rt_dep)) begin
      w_hazard = 1'b1;
    end else begin
      w_hazard = 1'b0;
    end
  end

  // EX pipeline register with reset > flush > stall > load priority.
  always_ff @(posedge clk) begin
    if (reset || flush || w_hazard) begin
      r_ex_valid     <= 1'b0;
      r_ex_rs        <= {ADDR_W{1'b0}};
      r_ex_rt        <= {ADDR_W{1'b0}};
      r_ex_wn        <= {ADDR_W{1'b0}};
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_op_a      <= {DATA_W{1'b0}};
      r_ex_op_b      <= {DATA_W{1'b0}};
    end else begin
      r_ex_valid     <= id_valid;
      r_ex_rs        <= id_rs;
      r_ex_rt        <= id_rt;
      r_ex_wn        <= id_wn;
      r_ex_reg_write <= id_reg_write && id_valid;
      r_ex_mem_read  <= id_mem_read && id_valid;
      r_ex_op_a      <= w_op_a;
      r_ex_op_b      <= w_op_b;
    end
  end

  // Saturating count of hazard bubbles; flush bubbles are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_count <= {CNT_W{1'b0}};
    end else if (!flush && w_hazard && (r_bubble_count != {CNT_W{1'b1}})) begin
      r_bubble_count <= r_bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_bubble_count <= r_bubble_count;
    end
  end

  assign hazard_stall = w_hazard;
  assign ex_valid     = r_ex_valid;
  assign ex_rs        = r_ex_rs;
  assign ex_rt        = r_ex_rt;
  assign ex_wn        = r_ex_wn;
  assign ex_reg_write = r_ex_reg_write;
  assign ex_mem_read  = r_ex_mem_read;
  assign ex_op_a      = r_ex_op_a;
  assign ex_op_b      = r_ex_op_b;
  assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: a driver applies directed vectors and queues
// hand-computed expectations; a monitor pops them and compares hazard_stall and EX state.
module tb_id_ex_operand_stage;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic        clk;
  logic        reset, flush, id_valid, id_uses_rt, id_reg_write, id_mem_read, wb_we;
  logic [4:0]  id_rs, id_rt, id_wn, wb_wn;
  logic [31:0] rd1, rd2, wb_wd;
  logic        hazard_stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rs, ex_rt, ex_wn;
  logic [31:0] ex_op_a, ex_op_b;
  logic [1:0]  bubble_count;

  typedef struct {
    logic        hz;
    logic        v;
    logic [4:0]  rs, rt, wn;
    logic        rw, mr;
    logic [31:0] a, b;
    logic [1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  id_ex_operand_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_wn(id_wn),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .rd1(rd1), .rd2(rd2), .wb_we(wb_we), .wb_wn(wb_wn), .wb_wd(wb_wd),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wn(ex_wn), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .bubble_count(bubble_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input int item, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL item %0d %s: got %h expected %h", item, name, act, exp);
    end
  endfunction

  // Apply one vector after the edge and queue what the next edge should produce.
  task automatic step(
    input logic rst, input logic fl, input logic v,
    input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic [4:0] wn,
    input logic rw, input logic mr, input logic [31:0] r1, input logic [31:0] r2,
    input logic wwe, input logic [4:0] wwn, input logic [31:0] wwd,
    input logic ehz, input logic ev, input logic [31:0] ea, input logic [31:0] eb,
    input logic [1:0] ec);
    exp_t e;
    @(posedge clk);
    #2;
    reset = rst; flush = fl; id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_wn = wn; id_reg_write = rw; id_mem_read = mr; rd1 = r1; rd2 = r2;
    wb_we = wwe; wb_wn = wwn; wb_wd = wwd;
    e.hz  = ehz;
    e.v   = ev;
    e.rs  = ev ? rs : 5'd0;
    e.rt  = ev ? rt : 5'd0;
    e.wn  = ev ? wn : 5'd0;
    e.rw  = ev & rw;
    e.mr  = ev & mr;
    e.a   = ea;
    e.b   = eb;
    e.cnt = ec;
    exp_q.push_back(e);
  endtask

  // Monitor: hazard_stall mid-cycle for the applied inputs, EX state just after the edge.
  initial begin
    exp_t e;
    int   n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n++;
        chk(n, "hazard_stall", 32'(hazard_stall), 32'(e.hz));
        @(posedge clk);
        #1;
        chk(n, "ex_valid", 32'(ex_valid), 32'(e.v));
        chk(n, "ex_rs", 32'(ex_rs), 32'(e.rs));
        chk(n, "ex_rt", 32'(ex_rt), 32'(e.rt));
        chk(n, "ex_wn", 32'(ex_wn), 32'(e.wn));
        chk(n, "ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
        chk(n, "ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
        chk(n, "ex_op_a", ex_op_a, e.a);
        chk(n, "ex_op_b", ex_op_b, e.b);
        chk(n, "bubble_count", 32'(bubble_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    reset = T; flush = F; id_valid = T; id_rs = 5'd3; id_rt = 5'd4; id_uses_rt = T;
    id_wn = 5'd3; id_reg_write = T; id_mem_read = T; rd1 = 32'h1; rd2 = 32'h2;
    wb_we = F; wb_wn = 5'd0; wb_wd = 32'h0;
    // reset held with a valid instruction presented
    step(T,F,T,5'd3,5'd4,T,5'd3,T,T,32'h1,32'h2,F,5'd0,32'h0, F,F,32'h0,32'h0,2'd0);
    step(T,F,T,5'd3,5'd4,T,5'd3,T,T,32'h1,32'h2,F,5'd0,32'h0, F,F,32'h0,32'h0,2'd0);
    // pass-through, rs bypass, r0 never bypassed, rt bypass
    step(F,F,T,5'd3,5'd4,T,5'd8,T,F,32'h11,32'h22,F,5'd0,32'h0, F,T,32'h11,32'h22,2'd0);
    step(F,F,T,5'd5,5'd6,T,5'd9,T,F,32'hDEAD,32'h66,T,5'd5,32'hBEEF, F,T,32'hBEEF,32'h66,2'd0);
    step(F,F,T,5'd0,5'd6,T,5'd9,T,F,32'h123,32'h77,T,5'd0,32'h5555, F,T,32'h0,32'h77,2'd0);
    step(F,F,T,5'd1,5'd2,T,5'd10,T,F,32'hA,32'hB,T,5'd2,32'hC, F,T,32'hA,32'hC,2'd0);
    // load r7, dependent stalls once, then enters EX
    step(F,F,T,5'd1,5'd0,F,5'd7,T,T,32'h100,32'h0,F,5'd0,32'h0, F,T,32'h100,32'h0,2'd0);
    step(F,F,T,5'd7,5'd3,T,5'd11,T,F,32'h70,32'h30,F,5'd0,32'h0, T,F,32'h0,32'h0,2'd1);
    step(F,F,T,5'd7,5'd3,T,5'd11,T,F,32'h70,32'h30,F,5'd0,32'h0, F,T,32'h70,32'h30,2'd1);
    // rt matches the load but is not read: no stall
    step(F,F,T,5'd1,5'd0,F,5'd7,T,T,32'h200,32'h0,F,5'd0,32'h0, F,T,32'h200,32'h0,2'd1);
    step(F,F,T,5'd2,5'd7,F,5'd12,T,F,32'h5,32'h6,F,5'd0,32'h0, F,T,32'h5,32'h6,2'd1);
    // flush during hazard (with a bypass): bubble, count unchanged
    step(F,F,T,5'd1,5'd0,F,5'd7,T,T,32'h300,32'h0,F,5'd0,32'h0, F,T,32'h300,32'h0,2'd1);
    step(F,T,T,5'd7,5'd0,F,5'd13,T,F,32'h77,32'h99,T,5'd7,32'hAAAA, F,F,32'h0,32'h0,2'd1);
    step(F,F,T,5'd7,5'd0,F,5'd13,T,F,32'h77,32'h99,F,5'd0,32'h0, F,T,32'h77,32'h0,2'd1);
    // chained dependent loads drive the counter to saturation
    step(F,F,T,5'd1,5'd0,F,5'd7,T,T,32'h1,32'h0,F,5'd0,32'h0, F,T,32'h1,32'h0,2'd1);
    step(F,F,T,5'd7,5'd0,F,5'd7,T,T,32'h2,32'h0,F,5'd0,32'h0, T,F,32'h0,32'h0,2'd2);
    step(F,F,T,5'd7,5'd0,F,5'd7,T,T,32'h2,32'h0,F,5'd0,32'h0, F,T,32'h2,32'h0,2'd2);
    step(F,F,T,5'd7,5'd0,F,5'd7,T,T,32'h3,32'h0,F,5'd0,32'h0, T,F,32'h0,32'h0,2'd3);
    step(F,F,T,5'd7,5'd0,F,5'd7,T,T,32'h3,32'h0,F,5'd0,32'h0, F,T,32'h3,32'h0,2'd3);
    step(F,F,T,5'd7,5'd0,F,5'd7,T,T,32'h4,32'h0,F,5'd0,32'h0, T,F,32'h0,32'h0,2'd3);
    step(F,F,T,5'd7,5'd0,F,5'd7,T,T,32'h4,32'h0,F,5'd0,32'h0, F,T,32'h4,32'h0,2'd3);
    step(F,F,T,5'd7,5'd0,F,5'd7,T,T,32'h5,32'h0,F,5'd0,32'h0, T,F,32'h0,32'h0,2'd3);
    step(F,F,T,5'd7,5'd0,F,5'd7,T,T,32'h5,32'h0,F,5'd0,32'h0, F,T,32'h5,32'h0,2'd3);
    // reset while the load-use condition holds, then idle
    step(T,F,T,5'd7,5'd0,F,5'd7,T,T,32'h6,32'h0,F,5'd0,32'h0, F,F,32'h0,32'h0,2'd0);
    step(F,F,F,5'd0,5'd0,F,5'd0,F,F,32'h0,32'h0,F,5'd0,32'h0, F,F,32'h0,32'h0,2'd0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d items left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
